exec_wb_scheduler: RTL and testbench

- Control-only successor to the fixed wait-bit tracking in the execution stage.
- Generalised to NUM_UNITS fixed-latency functional units (mem, fadd, fmul, fdiv, sqrt, floor, ftoi, itof, ...), each with its own parametrised latency.
- Keeps a writeback reservation shift register that decides issue legality: RAW, WAW and writeback-port conflicts. It also produces per-operand forwarding selects and the single writeback command.
- Sits between decode/operand read and the datapath muxes; it carries no data.

---
 rtl/exec_pkg.sv | 40 ++++
 rtl/exec_hazard_scan.sv | 39 +++
 rtl/exec_wb_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_exec_wb_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg
// Shared definitions for the execution-stage writeback scheduler:
//   - functional unit ids and their default latencies
//   - wb_slot_t, one writeback reservation {valid, rd, fmode, unit}
//   - reg_match(), the register-equality rule used by all hazard checks
package exec_pkg;

    localparam int EXEC_UID_W = 3;

    localparam int UNIT_MEM   = 0;
    localparam int UNIT_FADD  = 1;
    localparam int UNIT_FMUL  = 2;
    localparam int UNIT_FDIV  = 3;
    localparam int UNIT_SQRT  = 4;
    localparam int UNIT_FLOOR = 5;
    localparam int UNIT_FTOI  = 6;
    localparam int UNIT_ITOF  = 7;

    // 4-bit latency per unit, unit 0 in the least significant nibble.
    localparam logic [31:0] DEFAULT_UNIT_LAT =
        {4'd2, 4'd1, 4'd2, 4'd6, 4'd11, 4'd4, 4'd4, 4'd1};

    typedef struct packed {
        logic                  valid;
        logic [4:0]            rd;
        logic                  fmode;
        logic [EXEC_UID_W-1:0] unit;
    } wb_slot_t;

    // Same register file and number. Integer r0 is hardwired, so it never
    // creates a dependency.
    function automatic logic reg_match(input logic       fmode_a,
                                       input logic [4:0] no_a,
                                       input logic       fmode_b,
                                       input logic [4:0] no_b);
        return (fmode_a == fmode_b) && (no_a == no_b) &&
               !((fmode_a == 1'b0) && (no_a == 5'd0));
    endfunction

endpackage

// File: rtl/exec_hazard_scan.sv
// exec_hazard_scan
// Scans the reservation slots for the nearest pending write to one source
// operand.
//   slots_i     : reservation array, slot k writes back k cycles from now
//   used_i      : operand is actually read
//   src_no_i    : source register number
//   src_fmode_i : source register file (1 = float)
//   hit_o       : some valid slot matches
//   idx_o       : smallest matching slot index (valid only with hit_o)
module exec_hazard_scan
    import exec_pkg::*;
#(
    parameter int MAX_LAT = 12,
    parameter int IDX_W   = 4
) (
    input  wb_slot_t [MAX_LAT-1:0] slots_i,
    input  logic                   used_i,
    input  logic [4:0]             src_no_i,
    input  logic                   src_fmode_i,
    output logic                   hit_o,
    output logic [IDX_W-1:0]       idx_o
);

    // Walk from the far end so the nearest match overwrites later ones.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        if (used_i) begin
            for (int k = MAX_LAT - 1; k >= 0; k--) begin
                if (slots_i[k].valid &&
                    reg_match(slots_i[k].fmode, slots_i[k].rd, src_fmode_i, src_no_i)) begin
                    hit_o = 1'b1;
                    idx_o = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/exec_wb_scheduler.sv
// exec_wb_scheduler
// Issue-legality and writeback scheduling for fixed-latency functional
// units. A reservation shift register holds every pending write; slot 0 is
// the write happening this cycle. No data passes through this block.
//   clk, rstn              : clock, asynchronous active-low reset
//   flush                  : discard all reservations at the next edge
//   issue_*                : decoded instruction (unit, destination)
//   rs_*, rt_*             : source operands (used, number, file)
//   issue_ready            : combinational acceptance
//   fwd_rs, fwd_rt         : take operand from this cycle's result bus
//   wb_valid/rd/fmode/unit : registered writeback command (slot 0)
//   inflight               : number of valid reservations
module exec_wb_scheduler
    import exec_pkg::*;
#(
    parameter int                     NUM_UNITS = 8,
    parameter int                     UID_W     = 3,
    parameter int                     MAX_LAT   = 12,
    parameter logic [4*NUM_UNITS-1:0] UNIT_LAT  = DEFAULT_UNIT_LAT,
    parameter int                     CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [UID_W-1:0] issue_unit,
    input  logic             issue_wr,
    input  logic [4:0]       issue_rd,
    input  logic             issue_fmode,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic [4:0]       rs_no,
    input  logic [4:0]       rt_no,
    input  logic             rs_fmode,
    input  logic             rt_fmode,
    output logic             issue_ready,
    output logic             fwd_rs,
    output logic             fwd_rt,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_fmode,
    output logic [UID_W-1:0] wb_unit,
    output logic [CNT_W-1:0] inflight
);

    localparam int IDX_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    if (UID_W != EXEC_UID_W) begin : g_bad_uid_w
        $fatal(1, "exec_wb_scheduler: UID_W must equal the slot unit field width");
    end
    if (NUM_UNITS > (2 ** UID_W)) begin : g_bad_num_units
        $fatal(1, "exec_wb_scheduler: NUM_UNITS does not fit in UID_W");
    end
    if (MAX_LAT >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $fatal(1, "exec_wb_scheduler: CNT_W cannot hold MAX_LAT");
    end
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_lat_chk
        if ((UNIT_LAT[4*u +: 4] == 4'd0) || (int'(UNIT_LAT[4*u +: 4]) > MAX_LAT)) begin : g_bad_lat
            $fatal(1, "exec_wb_scheduler: unit latency out of range");
        end
    end

    wb_slot_t [MAX_LAT-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;

    logic             unit_ok;
    logic [3:0]       lat;
    logic             waw_hzd;
    logic             port_hzd;
    logic             raw_hzd;
    logic             rs_hit, rt_hit;
    logic [IDX_W-1:0] rs_idx, rt_idx;
    logic             accept_wr;
    wb_slot_t         new_slot;

    exec_hazard_scan #(.MAX_LAT(MAX_LAT), .IDX_W(IDX_W)) u_scan_rs (
        .slots_i     (slot_q),
        .used_i      (rs_used),
        .src_no_i    (rs_no),
        .src_fmode_i (rs_fmode),
        .hit_o       (rs_hit),
        .idx_o       (rs_idx)
    );

    exec_hazard_scan #(.MAX_LAT(MAX_LAT), .IDX_W(IDX_W)) u_scan_rt (
        .slots_i     (slot_q),
        .used_i      (rt_used),
        .src_no_i    (rt_no),
        .src_fmode_i (rt_fmode),
        .hit_o       (rt_hit),
        .idx_o       (rt_idx)
    );

    // Latency lookup; an out-of-range unit id is a decode error and blocks issue.
    always_comb begin
        unit_ok = 1'b0;
        lat     = 4'd1;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (issue_unit == UID_W'(u)) begin
                unit_ok = 1'b1;
                lat     = UNIT_LAT[4*u +: 4];
            end
        end
    end

    // WAW includes slot 0. The port check looks at slot[L] because that entry
    // lands in slot[L-1] at the same edge the new reservation would.
    always_comb begin
        waw_hzd  = 1'b0;
        port_hzd = 1'b0;
        if (issue_wr) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (slot_q[k].valid) begin
                    if (reg_match(slot_q[k].fmode, slot_q[k].rd, issue_fmode, issue_rd)) begin
                        waw_hzd = 1'b1;
                    end
                    if (int'(lat) == k) begin
                        port_hzd = 1'b1;
                    end
                end
            end
        end
    end

    // Slot 0 is on the result bus this cycle, so it forwards instead of stalling.
    assign raw_hzd = (rs_hit && (rs_idx != '0)) || (rt_hit && (rt_idx != '0));
    assign fwd_rs  = rs_hit && (rs_idx == '0);
    assign fwd_rt  = rt_hit && (rt_idx == '0);

    assign issue_ready = ~flush & unit_ok & ~raw_hzd & ~waw_hzd & ~port_hzd;
    assign accept_wr   = issue_valid & issue_ready & issue_wr;

    always_comb begin
        new_slot       = '0;
        new_slot.valid = 1'b1;
        new_slot.rd    = issue_rd;
        new_slot.fmode = issue_fmode;
        new_slot.unit  = issue_unit;
    end

    always_comb begin
        slot_d = '0;
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        if (accept_wr) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (int'(lat) - 1 == k) begin
                    slot_d[k] = new_slot;
                end
            end
        end
        if (flush) begin
            slot_d = '0;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept_wr, slot_q[0].valid})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        if (flush) begin
            inflight_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_q     <= '0;
            inflight_q <= '0;
        end else begin
            slot_q     <= slot_d;
            inflight_q <= inflight_d;
        end
    end

    assign wb_valid = slot_q[0].valid;
    assign wb_rd    = slot_q[0].rd;
    assign wb_fmode = slot_q[0].fmode;
    assign wb_unit  = slot_q[0].unit;
    assign inflight = inflight_q;

endmodule

// File: tb/tb_exec_wb_scheduler.sv
module tb_exec_wb_scheduler;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic       issue_valid;
    logic [2:0] issue_unit;
    logic       issue_wr;
    logic [4:0] issue_rd;
    logic       issue_fmode;
    logic       rs_used, rt_used;
    logic [4:0] rs_no, rt_no;
    logic       rs_fmode, rt_fmode;
    logic       issue_ready;
    logic       fwd_rs, fwd_rt;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_fmode;
    logic [2:0] wb_unit;
    logic [3:0] inflight;

    exec_wb_scheduler dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_unit  (issue_unit),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_fmode (issue_fmode),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .rs_no       (rs_no),
        .rt_no       (rt_no),
        .rs_fmode    (rs_fmode),
        .rt_fmode    (rt_fmode),
        .issue_ready (issue_ready),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_fmode    (wb_fmode),
        .wb_unit     (wb_unit),
        .inflight    (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: list of pending writes with absolute due cycles.
    typedef struct {
        int due;
        int rd;
        bit fm;
        int unit;
    } pend_t;

    pend_t q[$];
    int    now = 0;
    int    lat_tab[8] = '{1, 4, 4, 11, 6, 2, 1, 2};

    function automatic bit rmatch(bit fa, int na, bit fb, int nb);
        return (fa == fb) && (na == nb) && !(fa == 1'b0 && na == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_eval(output bit rdy, output bit fr, output bit ft,
                              output bit wv, output int wrd, output bit wfm, output int wun);
        int  best_rs, best_rt, k, l;
        bit  waw, port;
        best_rs = 1000;
        best_rt = 1000;
        waw = 0; port = 0;
        wv = 0; wrd = 0; wfm = 0; wun = 0;
        l = lat_tab[int'(issue_unit)];
        foreach (q[i]) begin
            k = q[i].due - now;
            if (rs_used && rmatch(q[i].fm, q[i].rd, rs_fmode, int'(rs_no)) && k < best_rs) best_rs = k;
            if (rt_used && rmatch(q[i].fm, q[i].rd, rt_fmode, int'(rt_no)) && k < best_rt) best_rt = k;
            if (issue_wr && rmatch(q[i].fm, q[i].rd, issue_fmode, int'(issue_rd))) waw = 1;
            if (issue_wr && k == l) port = 1;
            if (k == 0) begin
                wv = 1; wrd = q[i].rd; wfm = q[i].fm; wun = q[i].unit;
            end
        end
        fr  = (best_rs == 0);
        ft  = (best_rt == 0);
        rdy = !flush && !waw && !port &&
              !(best_rs >= 1 && best_rs < 1000) && !(best_rt >= 1 && best_rt < 1000);
    endtask

    // Check one cycle against the model, clock it, advance the model.
    task automatic tick(input string tag);
        bit rdy, fr, ft, wv, wfm;
        int wrd, wun;
        #2;
        model_eval(rdy, fr, ft, wv, wrd, wfm, wun);
        chk({tag, ":ready"}, issue_ready, rdy);
        chk({tag, ":fwd_rs"}, fwd_rs, fr);
        chk({tag, ":fwd_rt"}, fwd_rt, ft);
        chk({tag, ":wb_valid"}, wb_valid, wv);
        chk({tag, ":inflight"}, inflight, q.size());
        if (wv) begin
            chk({tag, ":wb_rd"}, wb_rd, wrd);
            chk({tag, ":wb_fmode"}, wb_fmode, wfm);
            chk({tag, ":wb_unit"}, wb_unit, wun);
        end
        @(posedge clk);
        if (!rstn || flush) begin
            q.delete();
        end else begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].due == now) q.delete(i);
            end
            if (issue_valid && rdy && issue_wr) begin
                q.push_back('{due: now + lat_tab[int'(issue_unit)], rd: int'(issue_rd),
                              fm: issue_fmode, unit: int'(issue_unit)});
            end
        end
        now++;
        #1;
    endtask

    task automatic set_in(input bit v, input int unit, input bit wr, input int rd, input bit fm,
                          input bit rsu, input int rsn, input bit rsf,
                          input bit rtu, input int rtn, input bit rtf);
        issue_valid = v;
        issue_unit  = 3'(unit);
        issue_wr    = wr;
        issue_rd    = 5'(rd);
        issue_fmode = fm;
        rs_used     = rsu;
        rs_no       = 5'(rsn);
        rs_fmode    = rsf;
        rt_used     = rtu;
        rt_no       = 5'(rtn);
        rt_fmode    = rtf;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn  = 1'b0;
        flush = 1'b0;
        idle();
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_unit", wb_unit, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_ready", issue_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // FADD f3: writeback exactly 4 cycles after issue
        set_in(1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        tick("s1_issue");
        idle();
        #1 chk("s1_inflight1", inflight, 1);
        for (int i = 1; i <= 3; i++) begin
            #1 chk("s1_wb_early", wb_valid, 0);
            tick("s1_wait");
        end
        #1;
        chk("s1_wb_valid", wb_valid, 1);
        chk("s1_wb_rd", wb_rd, 3);
        chk("s1_wb_fmode", wb_fmode, 1);
        chk("s1_wb_unit", wb_unit, 1);
        tick("s1_wb");
        #1 chk("s1_inflight0", inflight, 0);
        chk("s1_wb_after", wb_valid, 0);
        tick("s1_done");

        // RAW stall then forward
        set_in(1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        tick("s2_issue");
        set_in(1, 2, 1, 8, 1, 1, 3, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            #1 chk("s2_stall", issue_ready, 0);
            tick("s2_wait");
        end
        #1 chk("s2_ready", issue_ready, 1);
        chk("s2_fwd", fwd_rs, 1);
        tick("s2_fwd");
        drain(5);

        // Writeback port conflict FDIV vs FMUL
        set_in(1, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        tick("s3_fdiv");
        idle();
        for (int i = 1; i <= 6; i++) tick("s3_wait");
        set_in(1, 2, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("s3_conflict", issue_ready, 0);
        tick("s3_c7");
        #1 chk("s3_accept", issue_ready, 1);
        tick("s3_c8");
        idle();
        tick("s3_c9");
        tick("s3_c10");
        #1 chk("s3_wb11_rd", wb_rd, 5);
        chk("s3_wb11_v", wb_valid, 1);
        tick("s3_c11");
        #1 chk("s3_wb12_rd", wb_rd, 6);
        chk("s3_wb12_unit", wb_unit, 2);
        tick("s3_c12");
        drain(2);

        // int r0 never a dependency; float f0 is
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("s4_int_issue");
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        #1 chk("s4_int_ready", issue_ready, 1);
        chk("s4_int_fwd", fwd_rs, 0);
        tick("s4_int_cons");
        drain(3);
        set_in(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tick("s4_fp_issue");
        set_in(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        #1 chk("s4_fp_stall", issue_ready, 0);
        tick("s4_fp_cons1");
        tick("s4_fp_cons2");
        drain(2);

        // WAW on f2, store slips through during the stall
        set_in(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        tick("s5_fdiv");
        for (int c = 1; c <= 11; c++) begin
            if (c == 3) begin
                set_in(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
                #1 chk("s5_store", issue_ready, 1);
            end else begin
                set_in(1, 7, 1, 2, 1, 0, 0, 0, 0, 0, 0);
                #1 chk("s5_waw", issue_ready, 0);
            end
            tick("s5_wait");
        end
        set_in(1, 7, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("s5_itof", issue_ready, 1);
        tick("s5_itof");
        drain(3);

        // Flush with three ops in flight
        set_in(1, 2, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        tick("s6_fmul");
        set_in(1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick("s6_fdiv");
        set_in(1, 4, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        tick("s6_sqrt");
        set_in(1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        #1 chk("s6_flush_ready", issue_ready, 0);
        tick("s6_flush");
        flush = 1'b0;
        idle();
        #1 chk("s6_inflight", inflight, 0);
        chk("s6_wb", wb_valid, 0);
        tick("s6_after");
        drain(3);

        // Asynchronous reset mid-flight
        set_in(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        tick("s7_fdiv");
        set_in(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        tick("s7_mem");
        set_in(1, 1, 1, 11, 1, 1, 4, 1, 0, 0, 0);
        #1 chk("s7_pre_wb", wb_valid, 1);
        chk("s7_pre_ready", issue_ready, 0);
        rstn = 1'b0;
        q.delete();
        #1;
        chk("s7_rst_wb_valid", wb_valid, 0);
        chk("s7_rst_wb_rd", wb_rd, 0);
        chk("s7_rst_wb_fmode", wb_fmode, 0);
        chk("s7_rst_inflight", inflight, 0);
        chk("s7_rst_ready", issue_ready, 1);
        chk("s7_rst_fwd", fwd_rs, 0);
        tick("s7_in_reset");
        rstn = 1'b1;
        drain(2);

        // Randomised traffic over a small register set to provoke hazards
        for (int n = 0; n < 500; n++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 39) == 0);
            tick("rnd");
        end
        flush = 1'b0;
        drain(13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
